// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with registered result/zero/ovf, serial shifter and valid/ready handshake
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake; in_ready is low while shifting or holding an unconsumed result
//   alu_ctr, src_a, src_b, shamt   operation code and operands, captured only on accept
//   out_valid / out_ready          result handshake
//   result, zero, ovf              registered outputs, stable while out_valid & ~out_ready
module alu_exec #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctr,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] work, work_n, res_c, sum, diff;
   logic [SHW-1:0]   count;
   logic             dir_right, accept, is_shift, serial, zero_c, ovf_c;
   assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign is_shift  = (alu_ctr == 4'b0101) | (alu_ctr == 4'b0110);
   assign serial    = is_shift & (shamt != '0);
   assign sum       = src_a + src_b;
   assign diff      = src_a - src_b;
   assign work_n    = dir_right ? (work >> 1) : (work << 1);
   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      case (alu_ctr)
         4'b0000: res_c = src_a & src_b;
         4'b0001: res_c = src_a | src_b;
         4'b0010: begin
            res_c = sum;
            ovf_c = (src_a[WIDTH-1] == src_b[WIDTH-1]) & (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         4'b0011: begin
            res_c = diff;
            ovf_c = (src_a[WIDTH-1] != src_b[WIDTH-1]) & (diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         4'b0100: res_c = ~(src_a | src_b);
         // a shift reaching here single-cycle has shamt=0, so it passes B through
         4'b0101: res_c = src_b;
         4'b0110: res_c = src_b;
         4'b1000: res_c = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         4'b1010: res_c = src_b << (WIDTH/2);
         default: res_c = '0;
      endcase
      // code 1111 is the branch compare: zero reports A==B rather than result==0
      zero_c = (alu_ctr == 4'b1111) ? (src_a == src_b) : (res_c == '0);
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? (serial ? SHIFT : DONE) : IDLE;
         SHIFT:   state_n = (count == SHW'(1)) ? DONE : SHIFT;
         DONE:    state_n = accept ? (serial ? SHIFT : DONE) : (out_ready ? IDLE : DONE);
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         work      <= '0;
         count     <= '0;
         dir_right <= 1'b0;
      end else if (accept && serial) begin
         work      <= src_b;
         count     <= shamt;
         dir_right <= alu_ctr[1];
      end else if (accept) begin
         result <= res_c;
         zero   <= zero_c;
         ovf    <= ovf_c;
      end else if (state == SHIFT) begin
         work  <= work_n;
         count <= count - SHW'(1);
         if (count == SHW'(1)) begin
            result <= work_n;
            zero   <= (work_n == '0);
            ovf    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vector table plus stall, back-to-back and reset-mid-shift sequences for alu_exec
module tb_alu_exec;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_ctr = '0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [4:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   int          total = 0;
   int          passed = 0;
   typedef struct {
      logic [3:0]  ctr;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        z;
      logic        o;
      int          lat;
   } vec_t;
   vec_t v[18];
   alu_exec #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctr(alu_ctr), .src_a(src_a), .src_b(src_b), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask
   task automatic run(input int idx, input vec_t t);
      int lat;
      int busy;
      @(negedge clk);
      alu_ctr  = t.ctr;
      src_a    = t.a;
      src_b    = t.b;
      shamt    = t.sh;
      in_valid = 1'b1;
      #1 chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      src_a    = ~t.a;
      src_b    = ~t.b;
      lat  = 1;
      busy = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) busy++;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(t.lat));
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'(t.lat - 1));
      chk($sformatf("v%0d result", idx), result, t.res);
      chk($sformatf("v%0d zero", idx), 32'(zero), 32'(t.z));
      chk($sformatf("v%0d ovf", idx), 32'(ovf), 32'(t.o));
   endtask
   initial begin
      v[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1, 1};
      v[1]  = '{4'b1111, 32'h00001234, 32'h00001234, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
      v[2]  = '{4'b1111, 32'h00001234, 32'h00001235, 5'd0,  32'h00000000, 1'b0, 1'b0, 1};
      v[3]  = '{4'b0101, 32'h0,        32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 32};
      v[4]  = '{4'b0110, 32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 5};
      v[5]  = '{4'b0101, 32'h0,        32'h000000A5, 5'd0,  32'h000000A5, 1'b0, 1'b0, 1};
      v[6]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 1'b0, 1};
      v[7]  = '{4'b0001, 32'h0F000000, 32'h000000F0, 5'd0,  32'h0F0000F0, 1'b0, 1'b0, 1};
      v[8]  = '{4'b0100, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1};
      v[9]  = '{4'b0011, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1};
      v[10] = '{4'b0011, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
      v[11] = '{4'b1000, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0, 1};
      v[12] = '{4'b1000, 32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
      v[13] = '{4'b1010, 32'h0,        32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0, 1'b0, 1};
      v[14] = '{4'b0111, 32'h00000001, 32'h00000002, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
      v[15] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
      v[16] = '{4'b0110, 32'h0,        32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b0, 2};
      v[17] = '{4'b0010, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b1, 1};
      repeat (2) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst result", result, 32'h0);
      chk("rst zero", 32'(zero), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 18; i++) run(i, v[i]);
      // stall: sub held with out_ready low while a slt waits at the input
      @(negedge clk);
      out_ready = 1'b0;
      alu_ctr = 4'b0011; src_a = 32'd5; src_b = 32'd7; shamt = '0; in_valid = 1'b1;
      @(negedge clk);
      alu_ctr = 4'b1000; src_a = 32'hFFFFFFFF; src_b = 32'd1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stall%0d result", i), result, 32'hFFFFFFFE);
         chk($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("b2b in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b out_valid", 32'(out_valid), 32'd1);
      chk("b2b result", result, 32'h1);
      chk("b2b zero", 32'(zero), 32'd0);
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain result", result, 32'h1);
      // reset in the middle of a serial shift
      alu_ctr = 4'b0110; src_b = 32'hFFFFFFFF; shamt = 5'd20; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("midshift in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst out_valid", 32'(out_valid), 32'd0);
      chk("arst result", result, 32'h0);
      chk("arst in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'd1);
      chk("post-rst out_valid", 32'(out_valid), 32'd0);
      run(99, '{4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1});
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
